// File: rtl/execute_muldiv_if.sv
// execute_muldiv_if: decode-to-execute bundle for the execute stage.
// The master drives the decode-side fields; the slave returns stall and _e fields.
interface execute_muldiv_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     flush;
  logic                     valid_d;
  logic                     reg_write_d;
  logic                     mem_write_d;
  logic                     muldiv_d;
  logic [1:0]               result_src_d;
  logic [2:0]               funct3_d;
  logic [4:0]               rd_d;
  logic [DATA_WIDTH-1:0]    src_a_d;
  logic [DATA_WIDTH-1:0]    src_b_d;
  logic [DATA_WIDTH-1:0]    alu_result_d;
  logic [DATA_WIDTH-1:0]    write_data_d;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_d;
  logic                     stall;
  logic                     valid_e;
  logic                     reg_write_e;
  logic                     mem_write_e;
  logic [1:0]               result_src_e;
  logic [2:0]               funct3_e;
  logic [4:0]               rd_e;
  logic [DATA_WIDTH-1:0]    alu_result_e;
  logic [DATA_WIDTH-1:0]    write_data_e;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_e;

  modport master (
    output flush, valid_d, reg_write_d, mem_write_d, muldiv_d,
    output result_src_d, funct3_d, rd_d,
    output src_a_d, src_b_d, alu_result_d, write_data_d, pc_plus4_d,
    input  stall, valid_e, reg_write_e, mem_write_e,
    input  result_src_e, funct3_e, rd_e,
    input  alu_result_e, write_data_e, pc_plus4_e
  );

  modport slave (
    input  flush, valid_d, reg_write_d, mem_write_d, muldiv_d,
    input  result_src_d, funct3_d, rd_d,
    input  src_a_d, src_b_d, alu_result_d, write_data_d, pc_plus4_d,
    output stall, valid_e, reg_write_e, mem_write_e,
    output result_src_e, funct3_e, rd_e,
    output alu_result_e, write_data_e, pc_plus4_e
  );
endinterface

// File: rtl/execute_muldiv.sv
// execute_muldiv: execute stage with an iterative RV32M multiply/divide unit.
// ALU ops pass in one cycle; MUL/DIV stall decode for DATA_WIDTH+1 cycles.
module execute_muldiv #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic             clk,
  input  logic             rst,
  execute_muldiv_if.slave  bus
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDRESS_WIDTH;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  typedef struct packed {
    logic          valid;
    logic          reg_write;
    logic          mem_write;
    logic [1:0]    result_src;
    logic [2:0]    funct3;
    logic [4:0]    rd;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] write_data;
    logic [AW-1:0] pc_plus4;
  } ex_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] opnd_q, opnd_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic          sa_q, sa_d;
  logic          sb_q, sb_d;
  logic [2:0]    op_q, op_d;
  ex_t           ex_q, ex_d;

  logic          a_sgn, b_sgn;
  logic          sa_in, sb_in;
  logic [DW-1:0] a_mag, b_mag;
  logic [DW:0]   mul_sum;
  logic [DW:0]   div_sh;
  logic [DW-1:0] div_dif;
  logic          div_ge;
  logic [2*DW-1:0] prod;
  logic [DW-1:0] quo, rem, md_res;
  ex_t           ld;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (bus.funct3_d)
      3'b001, 3'b100, 3'b110: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      3'b010:  a_sgn = 1'b1;
      default: ;
    endcase
    sa_in = a_sgn & bus.src_a_d[DW-1];
    sb_in = b_sgn & bus.src_b_d[DW-1];
    a_mag = sa_in ? -bus.src_a_d : bus.src_a_d;
    b_mag = sb_in ? -bus.src_b_d : bus.src_b_d;
  end

  // mul: {hi,lo} is a right-shifting accumulator, lo starts as the multiplier
  // div: restoring divide, hi is the partial remainder, lo collects quotient
  always_comb begin
    mul_sum = {1'b0, hi_q} + ({(DW+1){lo_q[0]}} & {1'b0, opnd_q});
    div_sh  = {hi_q, lo_q[DW-1]};
    div_ge  = div_sh >= {1'b0, opnd_q};
    div_dif = div_sh[DW-1:0] - opnd_q;
  end

  always_comb begin
    prod = (sa_q ^ sb_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo  = (sa_q ^ sb_q) ? -lo_q : lo_q;
    rem  = sa_q ? -hi_q : hi_q;
    if (op_q == 3'b000)
      md_res = prod[DW-1:0];
    else if (!op_q[2])
      md_res = prod[2*DW-1:DW];
    else if (op_q[1])
      md_res = rem;
    else if (opnd_q == '0)
      md_res = '1;
    else
      md_res = quo;
  end

  always_comb begin
    ld.valid      = 1'b1;
    ld.reg_write  = bus.reg_write_d;
    ld.mem_write  = bus.mem_write_d;
    ld.result_src = bus.result_src_d;
    ld.funct3     = bus.funct3_d;
    ld.rd         = bus.rd_d;
    ld.alu_result = (state_q == DONE) ? md_res : bus.alu_result_d;
    ld.write_data = bus.write_data_d;
    ld.pc_plus4   = bus.pc_plus4_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      op_q    <= '0;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      op_q    <= op_d;
      ex_q    <= ex_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush)
      state_d = IDLE;
    else
      unique case (state_q)
        IDLE: if (bus.valid_d && bus.muldiv_d) state_d = BUSY;
        BUSY: if (cnt_q == CW'(DW-1)) state_d = DONE;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    op_d      = op_q;
    ex_d      = '0;
    bus.stall = 1'b0;
    if (!bus.flush) begin
      unique case (state_q)
        IDLE: begin
          if (bus.valid_d && bus.muldiv_d) begin
            bus.stall = 1'b1;
            cnt_d     = '0;
            op_d      = bus.funct3_d;
            sa_d      = sa_in;
            sb_d      = sb_in;
            hi_d      = '0;
            opnd_d    = bus.funct3_d[2] ? b_mag : a_mag;
            lo_d      = bus.funct3_d[2] ? a_mag : b_mag;
          end else if (bus.valid_d) begin
            ex_d = ld;
          end
        end
        BUSY: begin
          bus.stall = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (op_q[2]) begin
            hi_d = div_ge ? div_dif : div_sh[DW-1:0];
            lo_d = {lo_q[DW-2:0], div_ge};
          end else begin
            hi_d = mul_sum[DW:1];
            lo_d = {mul_sum[0], lo_q[DW-1:1]};
          end
        end
        DONE:    ex_d = ld;
        default: ;
      endcase
    end
    if (rst) bus.stall = 1'b0;
  end

  assign bus.valid_e      = ex_q.valid;
  assign bus.reg_write_e  = ex_q.reg_write;
  assign bus.mem_write_e  = ex_q.mem_write;
  assign bus.result_src_e = ex_q.result_src;
  assign bus.funct3_e     = ex_q.funct3;
  assign bus.rd_e         = ex_q.rd;
  assign bus.alu_result_e = ex_q.alu_result;
  assign bus.write_data_e = ex_q.write_data;
  assign bus.pc_plus4_e   = ex_q.pc_plus4;
endmodule
